// File: rtl/arb_req_ctrl.sv
// -----------------------------------------------------------------------------
// arb_req_ctrl
// Requester-side controller for the fixed-priority channel arbiter in the 8x8
// optical switch control path. Per-channel requests accumulate in a pending
// set. That set is presented as a frozen arbitration request together with a
// one-hot first-priority vector. The returned grant is captured, and channel
// ownership is held until the owner releases or the hold timeout fires. First
// priority then rotates past the last owner to give round-robin fairness.
//
// Parameters
//   P_CHANNEL_NUM  number of requesting channels (width of channel vectors)
//   P_HOLD_MAX     max ownership cycles before forced release; 0 disables it
//   P_CNT_W        hold-counter width; must hold P_HOLD_MAX-1
//
// Ports
//   i_clk                 clock
//   i_rst                 asynchronous active-high reset
//   i_ch_req              per-channel request pulses/levels (set pending bits)
//   i_ch_release          per-channel release; only the owner's bit counts
//   o_ch_grant            registered one-hot current owner (0 when none)
//   o_ch_grant_valid      high while an owner holds the grant
//   o_arb_req             pending snapshot presented to the arbiter
//   o_arb_first_priority  one-hot highest-priority channel for arbitration
//   o_arb_req_valid       arbitration request valid (held until grant sampled)
//   i_arb_grant           arbiter grant
//   i_arb_grant_valid     arbiter grant valid
//   o_timeout             one-cycle pulse on forced release
//   o_grant_err           one-cycle pulse on an illegal sampled grant
// -----------------------------------------------------------------------------
module arb_req_ctrl #(
    parameter int P_CHANNEL_NUM = 8,
    parameter int P_HOLD_MAX    = 1024,
    parameter int P_CNT_W       = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [P_CHANNEL_NUM-1:0] i_ch_req,
    input  logic [P_CHANNEL_NUM-1:0] i_ch_release,
    output logic [P_CHANNEL_NUM-1:0] o_ch_grant,
    output logic                     o_ch_grant_valid,
    output logic [P_CHANNEL_NUM-1:0] o_arb_req,
    output logic [P_CHANNEL_NUM-1:0] o_arb_first_priority,
    output logic                     o_arb_req_valid,
    input  logic [P_CHANNEL_NUM-1:0] i_arb_grant,
    input  logic                     i_arb_grant_valid,
    output logic                     o_timeout,
    output logic                     o_grant_err
);

    localparam int N = P_CHANNEL_NUM;
    localparam logic [N-1:0] FP_RESET = {{(N-1){1'b0}}, 1'b1};
    localparam logic [P_CNT_W-1:0] HOLD_LAST =
        P_CNT_W'((P_HOLD_MAX == 0) ? 0 : P_HOLD_MAX - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARB     = 2'd1,
        HOLD    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [N-1:0]       pend_q, pend_d;
    logic [N-1:0]       clr;
    logic [N-1:0]       arb_req_q, arb_req_d;
    logic               arb_req_valid_q, arb_req_valid_d;
    logic [N-1:0]       grant_q, grant_d;
    logic               grant_valid_q, grant_valid_d;
    logic [N-1:0]       fp_q, fp_d;
    logic [P_CNT_W-1:0] cnt_q, cnt_d;
    logic               timeout_q, timeout_d;
    logic               err_q, err_d;
    logic               grant_legal;

    // Legal grant: exactly one bit set and that bit was actually requested.
    always_comb begin
        grant_legal = (i_arb_grant != '0)
                   && ((i_arb_grant & (i_arb_grant - N'(1))) == '0)
                   && ((i_arb_grant & ~arb_req_q) == '0);
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q         <= IDLE;
            pend_q          <= '0;
            arb_req_q       <= '0;
            arb_req_valid_q <= 1'b0;
            grant_q         <= '0;
            grant_valid_q   <= 1'b0;
            fp_q            <= FP_RESET;
            cnt_q           <= '0;
            timeout_q       <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend_q          <= pend_d;
            arb_req_q       <= arb_req_d;
            arb_req_valid_q <= arb_req_valid_d;
            grant_q         <= grant_d;
            grant_valid_q   <= grant_valid_d;
            fp_q            <= fp_d;
            cnt_q           <= cnt_d;
            timeout_q       <= timeout_d;
            err_q           <= err_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        clr             = '0;
        arb_req_d       = arb_req_q;
        arb_req_valid_d = arb_req_valid_q;
        grant_d         = grant_q;
        grant_valid_d   = grant_valid_q;
        fp_d            = fp_q;
        cnt_d           = cnt_q;
        timeout_d       = 1'b0;
        err_d           = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_q != '0) begin
                    arb_req_d       = pend_q;
                    arb_req_valid_d = 1'b1;
                    state_d         = ARB;
                end
            end
            ARB: begin
                if (i_arb_grant_valid) begin
                    arb_req_valid_d = 1'b0;
                    if (grant_legal) begin
                        grant_d       = i_arb_grant;
                        grant_valid_d = 1'b1;
                        clr           = i_arb_grant;
                        cnt_d         = '0;
                        state_d       = HOLD;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                cnt_d = cnt_q + P_CNT_W'(1);
                // A release wins over a same-cycle timeout.
                if ((i_ch_release & grant_q) != '0) begin
                    state_d = RELEASE;
                end else if ((P_HOLD_MAX != 0) && (cnt_q == HOLD_LAST)) begin
                    timeout_d = 1'b1;
                    state_d   = RELEASE;
                end
            end
            RELEASE: begin
                grant_d       = '0;
                grant_valid_d = 1'b0;
                fp_d          = {grant_q[N-2:0], grant_q[N-1]};
                state_d       = IDLE;
            end
            default: state_d = IDLE;
        endcase

        pend_d = (pend_q | i_ch_req) & ~clr;
    end

    assign o_ch_grant           = grant_q;
    assign o_ch_grant_valid     = grant_valid_q;
    assign o_arb_req            = arb_req_q;
    assign o_arb_first_priority = fp_q;
    assign o_arb_req_valid      = arb_req_valid_q;
    assign o_timeout            = timeout_q;
    assign o_grant_err          = err_q;

endmodule

// File: tb/tb_arb_req_ctrl.sv
module tb_arb_req_ctrl;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_ch_req = '0;
    logic [7:0] i_ch_release = '0;
    logic [7:0] o_ch_grant;
    logic       o_ch_grant_valid;
    logic [7:0] o_arb_req;
    logic [7:0] o_arb_first_priority;
    logic       o_arb_req_valid;
    logic [7:0] i_arb_grant;
    logic       i_arb_grant_valid;
    logic       o_timeout;
    logic       o_grant_err;

    // Stub arbiter: rotating fixed-priority pick, or a forced bad value.
    logic       stub_bad = 1'b0;
    logic [7:0] stub_val = '0;
    logic [7:0] rr_pick;

    int checks = 0;
    int fails  = 0;

    always #5 i_clk = ~i_clk;

    arb_req_ctrl #(
        .P_CHANNEL_NUM(8),
        .P_HOLD_MAX   (16),
        .P_CNT_W      (16)
    ) dut (
        .i_clk               (i_clk),
        .i_rst               (i_rst),
        .i_ch_req            (i_ch_req),
        .i_ch_release        (i_ch_release),
        .o_ch_grant          (o_ch_grant),
        .o_ch_grant_valid    (o_ch_grant_valid),
        .o_arb_req           (o_arb_req),
        .o_arb_first_priority(o_arb_first_priority),
        .o_arb_req_valid     (o_arb_req_valid),
        .i_arb_grant         (i_arb_grant),
        .i_arb_grant_valid   (i_arb_grant_valid),
        .o_timeout           (o_timeout),
        .o_grant_err         (o_grant_err)
    );

    always_comb begin
        int start;
        rr_pick = '0;
        start   = 0;
        for (int i = 0; i < 8; i++)
            if (o_arb_first_priority[i]) start = i;
        for (int k = 7; k >= 0; k--)
            if (o_arb_req[(start + k) % 8]) rr_pick = 8'(1) << ((start + k) % 8);
    end

    assign i_arb_grant       = stub_bad ? stub_val : rr_pick;
    assign i_arb_grant_valid = o_arb_req_valid;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_grant"},    32'(o_ch_grant), 32'h00);
        check({tag, "_gvalid"},   32'(o_ch_grant_valid), 32'h0);
        check({tag, "_arbreq"},   32'(o_arb_req), 32'h00);
        check({tag, "_fp"},       32'(o_arb_first_priority), 32'h01);
        check({tag, "_arbvalid"}, 32'(o_arb_req_valid), 32'h0);
        check({tag, "_timeout"},  32'(o_timeout), 32'h0);
        check({tag, "_err"},      32'(o_grant_err), 32'h0);
    endtask

    task automatic release_ch(input logic [7:0] ch);
        i_ch_release = ch;
        tick();
        i_ch_release = '0;
        tick();
    endtask

    initial begin
        logic [7:0] exp_g;
        logic [7:0] seen;
        int n;

        // ---- reset ----
        #12;
        check_reset_outputs("rst");
        i_rst = 1'b0;
        tick();

        // ---- 1: single request, latency ----
        i_ch_req = 8'h10;
        tick();
        i_ch_req = '0;
        check("t1_novalid_yet", 32'(o_arb_req_valid), 32'h0);
        tick();
        check("t1_arbreq",  32'(o_arb_req), 32'h10);
        check("t1_fp",      32'(o_arb_first_priority), 32'h01);
        check("t1_arbvld",  32'(o_arb_req_valid), 32'h1);
        tick();
        check("t1_grant",   32'(o_ch_grant), 32'h10);
        check("t1_gvalid",  32'(o_ch_grant_valid), 32'h1);
        check("t1_arbvld0", 32'(o_arb_req_valid), 32'h0);
        i_ch_release = 8'h01;  // non-owner release is ignored
        tick();
        check("t1_nonowner_rel", 32'(o_ch_grant), 32'h10);
        i_ch_release = 8'h10;
        tick();
        i_ch_release = '0;
        check("t1_release_cycle_grant", 32'(o_ch_grant), 32'h10);
        tick();
        check("t1_grant_cleared", 32'(o_ch_grant), 32'h00);
        check("t1_fp_rot",        32'(o_arb_first_priority), 32'h20);

        // ---- 2: MSB owner wraps priority ----
        i_ch_req = 8'h81;
        tick();
        i_ch_req = '0;
        tick(2);
        check("t2_grant80", 32'(o_ch_grant), 32'h80);
        i_ch_release = 8'h80;
        tick();  // release sampled (edge r)
        i_ch_release = '0;
        tick();
        check("t2_fp_wrap", 32'(o_arb_first_priority), 32'h01);
        tick();
        check("t2_not_yet", 32'(o_ch_grant_valid), 32'h0);
        tick();
        check("t2_grant01", 32'(o_ch_grant), 32'h01);
        release_ch(8'h01);
        check("t2_fp02", 32'(o_arb_first_priority), 32'h02);

        // ---- 3: round-robin over all channels ----
        i_ch_req = 8'hFF;
        tick();
        i_ch_req = '0;
        exp_g = 8'h02;
        seen  = '0;
        for (int t = 0; t < 8; t++) begin
            n = 0;
            while (!o_ch_grant_valid && n < 10) begin
                tick();
                n++;
            end
            check("t3_wait_bound", 32'(n < 10), 32'h1);
            check("t3_rr_grant",   32'(o_ch_grant), 32'(exp_g));
            seen = seen | o_ch_grant;
            tick(3);
            release_ch(exp_g);
            exp_g = {exp_g[6:0], exp_g[7]};
        end
        check("t3_all_seen",  32'(seen), 32'hFF);
        check("t3_no_timeout_pending", 32'(o_arb_req_valid), 32'h0);

        // ---- 4: hold timeout (P_HOLD_MAX=16) ----
        i_ch_req = 8'h04;
        tick();
        i_ch_req = '0;
        tick(2);
        check("t4_grant04", 32'(o_ch_grant), 32'h04);
        tick(15);
        check("t4_no_timeout_early", 32'(o_timeout), 32'h0);
        check("t4_still_owned",      32'(o_ch_grant), 32'h04);
        tick();
        check("t4_timeout_pulse", 32'(o_timeout), 32'h1);
        tick();
        check("t4_timeout_done",  32'(o_timeout), 32'h0);
        check("t4_grant_zero",    32'(o_ch_grant), 32'h00);
        check("t4_fp08",          32'(o_arb_first_priority), 32'h08);

        // ---- 5: illegal grants ----
        stub_bad = 1'b1;
        stub_val = 8'h03;
        i_ch_req = 8'h03;
        tick();
        i_ch_req = '0;
        tick();
        check("t5_arbreq03", 32'(o_arb_req), 32'h03);
        tick();
        check("t5_err_multi", 32'(o_grant_err), 32'h1);
        check("t5_no_grant",  32'(o_ch_grant_valid), 32'h0);
        check("t5_fp_kept",   32'(o_arb_first_priority), 32'h08);
        stub_val = 8'h00;
        tick();
        check("t5_err_clr",   32'(o_grant_err), 32'h0);
        check("t5_retry_req", 32'(o_arb_req), 32'h03);
        tick();
        check("t5_err_zero",  32'(o_grant_err), 32'h1);
        stub_bad = 1'b0;
        tick(2);
        check("t5_clean_grant", 32'(o_ch_grant), 32'h01);
        check("t5_err_quiet",   32'(o_grant_err), 32'h0);
        release_ch(8'h01);
        tick(2);
        check("t5_grant02", 32'(o_ch_grant), 32'h02);
        release_ch(8'h02);

        // ---- 6: async reset in HOLD ----
        i_ch_req = 8'h01;
        tick();
        i_ch_req = 8'h0C;
        tick(2);
        i_ch_req = '0;
        check("t6_hold01", 32'(o_ch_grant), 32'h01);
        #2;
        i_rst = 1'b1;
        #1;
        check_reset_outputs("t6_rst");
        tick(2);
        i_rst = 1'b0;
        tick(4);
        check("t6_no_grant",  32'(o_ch_grant_valid), 32'h0);
        check("t6_no_arbreq", 32'(o_arb_req_valid), 32'h0);
        i_ch_req = 8'h02;
        tick();
        i_ch_req = '0;
        tick(2);
        check("t6_new_grant", 32'(o_ch_grant), 32'h02);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
